// File: rtl/multdiv_issue_ctrl.sv
// Issue/writeback controller for the execute-stage multiplier and divider.
// Latches one MULT or DIV request and issues a one-cycle start pulse. It then
// stalls the pipeline until the selected unit reports ready or the operation
// times out, and finally presents a single writeback beat.
module multdiv_issue_ctrl #(
    parameter int TIMEOUT       = 48,
    parameter int RSTATUS_REG   = 30,
    parameter int MULT_EXC_CODE = 4,
    parameter int DIV_EXC_CODE  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_op_mult,
    input  logic        in_op_div,
    input  logic [31:0] in_operandA,
    input  logic [31:0] in_operandB,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               accept;
    logic               op_div_q;
    logic [4:0]         rd_q;
    logic [CNT_W-1:0]   busy_count;
    logic               finish;
    logic               finish_exc;

    // A request is taken only when the controller is free (IDLE or the final
    // DONE beat), carries exactly one op bit, and is not being flushed.
    assign accept = in_valid & (in_op_mult ^ in_op_div) & ~flush &
                    ((state == IDLE) | (state == DONE));

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Flush wins over everything; RDY is only honoured in
    // BUSY because the unit's ready can be stale or combinational in START.
    always_comb begin
        next_state = state;
        finish     = 1'b0;
        finish_exc = 1'b0;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) next_state = START;
                end
                START: begin
                    next_state = BUSY;
                end
                BUSY: begin
                    if (md_resultRDY) begin
                        next_state = DONE;
                        finish     = 1'b1;
                        finish_exc = md_exception;
                    end else if (busy_count == CNT_W'(TIMEOUT - 1)) begin
                        next_state = DONE;
                        finish     = 1'b1;
                        finish_exc = 1'b1;
                    end
                end
                DONE: begin
                    next_state = accept ? START : IDLE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Start pulses and pipeline stall derived from the current state.
    always_comb begin
        ctrl_MULT = (state == START) & ~op_div_q & ~flush;
        ctrl_DIV  = (state == START) &  op_div_q & ~flush;
        stall     = (state == START) | (state == BUSY) | accept;
    end

    // Request registers change only on accept, so the units see stable
    // operands from START through DONE, and a flush leaves them untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_operandA <= '0;
            md_operandB <= '0;
            rd_q        <= '0;
            op_div_q    <= 1'b0;
        end else if (accept) begin
            md_operandA <= in_operandA;
            md_operandB <= in_operandB;
            rd_q        <= in_rd;
            op_div_q    <= in_op_div;
        end
    end

    // BUSY cycle counter, cleared in START so the first BUSY cycle reads 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_count <= '0;
        end else if (state == START) begin
            busy_count <= '0;
        end else if (state == BUSY) begin
            busy_count <= busy_count + CNT_W'(1);
        end
    end

    // Writeback beat is registered on the BUSY->DONE transition and is zero
    // in every other cycle; exceptions redirect to the status register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end else if (finish) begin
            wb_valid <= 1'b1;
            if (finish_exc) begin
                wb_rd        <= 5'(RSTATUS_REG);
                wb_data      <= op_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
                wb_exception <= 1'b1;
            end else begin
                wb_rd        <= rd_q;
                wb_data      <= md_result;
                wb_exception <= 1'b0;
            end
        end else begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end
    end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
- Issue/writeback controller upstream and downstream of the 32-bit multiplier/divider units in the execute stage.
- Accepts a MULT or DIV request from the pipeline, registers the operands and holds them stable for the whole operation. Issues the single-cycle ctrl_MULT/ctrl_DIV start pulse and stalls the pipeline until the unit's resultRDY is seen.
- Presents one writeback beat: the result, or an rstatus exception code.

Parameters:
- TIMEOUT, 48, max BUSY cycles before forced completion with exception.
- RSTATUS_REG, 30, writeback register on exception.
- MULT_EXC_CODE, 4, rstatus value on multiply exception/timeout.
- DIV_EXC_CODE, 5, rstatus value on divide exception/timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present this cycle.
- in_op_mult  in  1  request is MULT.
- in_op_div  in  1  request is DIV.
- in_operandA  in  32  multiplicand/dividend.
- in_operandB  in  32  multiplier/divisor.
- in_rd  in  5  destination register.
- flush  in  1  kill in-flight operation.
- md_operandA  out  32  registered operand A to the units.
- md_operandB  out  32  registered operand B to the units.
- ctrl_MULT  out  1  one-cycle multiplier start.
- ctrl_DIV  out  1  one-cycle divider start.
- md_result  in  32  selected unit result.
- md_exception  in  1  selected unit exception.
- md_resultRDY  in  1  selected unit ready.
- stall  out  1  hold upstream pipeline.
- wb_valid  out  1  writeback beat.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- wb_exception  out  1  writeback is an exception.

Behaviour:
- Clock and reset: single clock `clock`. Reset is asynchronous, active-high on `reset`.
- Reset values: state=IDLE; all outputs 0; operand, rd and op registers 0; timeout counter 0.
- States: IDLE, START, BUSY, DONE.
- Accept condition: in_valid & (in_op_mult ^ in_op_div) & ~flush, while in IDLE or DONE.
  - On accept: latch operands, in_rd and op; next state START.
  - in_valid with both op bits set or neither set: ignored, no stall.
- START (exactly 1 cycle):
  - Assert ctrl_MULT or ctrl_DIV per the latched op.
  - md_resultRDY and md_exception are ignored in this cycle: the unit counter is stale, and the divider raises RDY combinationally on B=0.
  - Clear the timeout counter. Next state BUSY.
- BUSY:
  - Counter increments each cycle.
  - md_resultRDY=1: capture md_result and md_exception; next state DONE.
  - Counter reaches TIMEOUT-1 without RDY: capture exception=1; next state DONE.
- DONE (exactly 1 cycle):
  - wb_valid=1.
  - Normal completion: wb_rd=latched rd, wb_data=captured result, wb_exception=0.
  - Exception or timeout: wb_rd=RSTATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE, wb_exception=1.
  - Next state is IDLE, or START if a new request is accepted (back-to-back).
- wb_* outputs are registered and are 0 outside DONE.
- stall = (state==START) | (state==BUSY) | accept.
  - The accept term is combinational, so stall is high in the request cycle.
  - stall is low in DONE unless a new accept occurs.
- md_operandA/B change only on accept. They are stable from START through DONE.
- flush, any state: next state IDLE. No ctrl pulse, no wb_valid. flush has priority over accept, RDY and timeout. Operand registers keep their values.
- reset asserted mid-operation: immediate return to IDLE with all outputs 0.
- Minimum latency: accept at cycle 0, START at 1, RDY sampled from 2, wb_valid at RDY cycle+1.

Test Plan:
- MULT 6×7, rd=3; stub RDY at BUSY cycle 17 -> ctrl_MULT high exactly 1 cycle; stall high from accept through BUSY; wb_valid 1 cycle, wb_rd=3, wb_data=42, wb_exception=0.
- DIV -20/3 with the real divider, rd=9 -> wb_data=0xFFFFFFFA, wb_rd=9; md_operandB=3 held for the whole op.
- DIV 7/0 -> RDY high in START is ignored; DONE at cycle 3; wb_rd=30, wb_data=5, wb_exception=1.
- flush asserted in the 5th BUSY cycle -> IDLE next cycle; stall drops; no wb_valid; a later MULT 2×3 completes with wb_data=6.
- Back-to-back: second request in the DONE cycle -> first wb beat emitted; START next cycle; no idle gap.
- Stub RDY never rises, MULT op -> wb at TIMEOUT+2 cycles after accept; wb_rd=30, wb_data=4. Async reset mid-BUSY -> all outputs 0 immediately.
